multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Sequencing controller for the multicycle ARM-subset datapath: a single register file, ALU, unified memory and instruction register, with PC/IR/flag updates spread over 3–5 cycles per instruction.
- Decodes the instruction fields and steps a Moore FSM through fetch/decode/execute/memory/writeback.
- Owns the architectural NZCV flag register and evaluates the 4-bit condition field once per instruction; all architectural writes are gated by that result.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.
- STATE_W, 4, width of the exported state code.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- Cond  in  4  Instr[31:28], condition field.
- Op  in  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (DP) / L (memory).
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  NZCV from the ALU, valid in the execute cycle.
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  write enables.
- AdrSrc  out  1  0=PC, 1=ALUOut as memory address.
- ALUSrcA  out  2  00=RD1, 01=PC, 10=ALUOut.
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ImmSrc, RegSrc, ALUControl  out  2 each  00 ADD, 01 SUB, 10 AND, 11 ORR.
- Flags  out  4  current NZCV register.
- State  out  STATE_W  current FSM state code, for debug/verification.

Behaviour:
- States and codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10–15 go to FETCH.
- FETCH: IRWrite=1, PCWrite=1 (unconditional), AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=ADD. Next state DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=10, ResultSrc=10. No writes.
  - Latch CondExReg = condition(Cond, Flags).
  - Next state: Op=01 → MEMADR; Op=00 with I=0 → EXECR; Op=00 with I=1 → EXECI; Op=10 → BRANCH; Op=11 → FETCH, with no writes.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. Next state MEMRD if L=1, else MEMWR.
- MEMRD: AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=01, RegW → FETCH.
- MEMWR: AdrSrc=1, MemW → FETCH.
- EXECR: ALUSrcB=00. EXECI: ALUSrcB=01. Both use ALUSrcA=00 and cmd-decoded ALUControl, then go to ALUWB.
- ALUWB: ResultSrc=00, RegW, except cmd=1010 (CMP: SUB, no RegW) → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch → FETCH.
- Condition evaluation: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL for codes 0–14. Code 15 evaluates false (never X).
- Write gating:
  - RegWrite = RegW & CondExReg.
  - MemWrite = MemW & CondExReg.
  - PCWrite = NextPC(FETCH) | (PCS & CondExReg), where PCS = Branch | (RegW & Rd==15).
  - When RegW & Rd==15, RegWrite is suppressed.
- Flag update:
  - Only in EXECR/EXECI, and only when S=1 and CondExReg=1.
  - ADD/SUB/CMP update NZ and CV. AND/ORR update NZ only.
  - The new Flags value is visible from the next cycle.
  - Flags never change in any other state.
- Immediate/register source select: ImmSrc=Op; RegSrc[0]=(Op==10), RegSrc[1]=(Op==01).
- Reset (reset=0 at an edge):
  - State←FETCH, Flags←RESET_FLAGS, CondExReg←0.
  - While reset=0, all write enables are forced to 0.
  - Reset asserted mid-instruction aborts that instruction with no further writes.
  - First cycle after release is FETCH.
- Latency (cycles, FETCH to next FETCH): LDR 5, STR 4, DP/CMP 4, B 3, undefined 2.

Decomposition:
- ctrl_pkg holds:
  - the state enum;
  - Op encodings;
  - ALUControl encodings;
  - the cmd constants (ADD=0100, SUB=0010, AND=0000, ORR=1100, CMP=1010);
  - the condition-code enum.
- One sub-module, cond_eval (combinational), maps Cond + Flags + ALUFlags + FlagW + CondEx to CondEx and FlagsNext. The controller instantiates it and owns the registers.

Test Plan:
- Reset for 2 cycles, then release → State=0, Flags=0000, IRWrite=1 and PCWrite=1 in the first cycle; write enables are 0 during reset.
- ADDS with I=1, Cond=1110, ALUFlags=0110 → states 0,1,7,8. Flags=0110 after EXECI. RegWrite=1 in ALUWB.
- Flags=0100 (Z); BNE (Cond=0001, Op=10) → states 0,1,9. PCWrite=0 in BRANCH. With Flags=0000, PCWrite=1.
- LDR (Op=01, L=1) → states 0,1,2,3,4. AdrSrc=1 in MEMRD, RegWrite=1 in MEMWB. STR → MemWrite=1 only in MEMWR.
- CMP with S=1, ALUFlags=1000 → Flags=1000, no RegWrite. ORRS with ALUFlags=0011 and prior Flags=1000 → Flags=0000 (CV preserved at 00).
- Op=11 → returns to FETCH after DECODE with no writes. Cond=1111 → no writes and no flag change. Reset asserted in MEMRD → no RegWrite; FETCH follows.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// instruction-class opcodes, ALU operations, DP cmd values, condition codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cond_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition check and next-NZCV computation. FlagW[1] enables
// the NZ pair, FlagW[0] the CV pair; both are gated by the latched condition.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondExReg,
  output logic       CondEx,
  output logic [3:0] FlagsNext
);

  logic n, z, c, v;
  assign {n, z, c, v} = Flags;

  // Evaluate the condition field against the current flag register
  always_comb begin
    CondEx = 1'b0;
    case (cond_t'(Cond))
      CC_EQ:   CondEx = z;
      CC_NE:   CondEx = ~z;
      CC_CS:   CondEx = c;
      CC_CC:   CondEx = ~c;
      CC_MI:   CondEx = n;
      CC_PL:   CondEx = ~n;
      CC_VS:   CondEx = v;
      CC_VC:   CondEx = ~v;
      CC_HI:   CondEx = c & ~z;
      CC_LS:   CondEx = ~c | z;
      CC_GE:   CondEx = (n == v);
      CC_LT:   CondEx = (n != v);
      CC_GT:   CondEx = ~z & (n == v);
      CC_LE:   CondEx = z | (n != v);
      CC_AL:   CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  // Merge ALU flags into the register value, pair by pair
  always_comb begin
    FlagsNext = Flags;
    if (FlagW[1] && CondExReg) FlagsNext[3:2] = ALUFlags[3:2];
    if (FlagW[0] && CondExReg) FlagsNext[1:0] = ALUFlags[1:0];
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM sequencer for the multicycle ARM-subset datapath. Owns the NZCV
// register and the per-instruction condition result that gates all writes.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         Cond,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic [3:0]         Rd,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUControl,
  output logic [3:0]         Flags,
  output logic [STATE_W-1:0] State
);

  state_t     state, state_nxt;
  logic [3:0] flags_q, flags_nxt;
  logic       condex_q, cond_ex;
  logic [1:0] flag_w;
  logic [1:0] alu_dec, flagw_dec;
  logic       irw, nextpc, regw, memw, branch, latch_cond, pcs, rd_pc;
  logic [3:0] cmd;

  assign cmd   = Funct[4:1];
  assign rd_pc = (Rd == 4'd15);

  cond_eval u_cond_eval (
    .Cond      (Cond),
    .Flags     (flags_q),
    .ALUFlags  (ALUFlags),
    .FlagW     (flag_w),
    .CondExReg (condex_q),
    .CondEx    (cond_ex),
    .FlagsNext (flags_nxt)
  );

  // Map the DP cmd to an ALU op and the flag pairs it may update
  always_comb begin
    alu_dec   = ALU_ADD;
    flagw_dec = 2'b11;
    case (cmd)
      CMD_ADD: begin alu_dec = ALU_ADD; flagw_dec = 2'b11; end
      CMD_SUB: begin alu_dec = ALU_SUB; flagw_dec = 2'b11; end
      CMD_CMP: begin alu_dec = ALU_SUB; flagw_dec = 2'b11; end
      CMD_AND: begin alu_dec = ALU_AND; flagw_dec = 2'b10; end
      CMD_ORR: begin alu_dec = ALU_ORR; flagw_dec = 2'b10; end
      default: begin alu_dec = ALU_ADD; flagw_dec = 2'b11; end
    endcase
  end

  // State register; reset restarts at FETCH
  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  // Architectural flags and the condition result latched in DECODE
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q  <= RESET_FLAGS;
      condex_q <= 1'b0;
    end else begin
      flags_q <= flags_nxt;
      if (latch_cond) condex_q <= cond_ex;
    end
  end

  // Next-state logic and Moore datapath controls
  always_comb begin
    state_nxt  = FETCH;
    irw        = 1'b0;
    nextpc     = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    branch     = 1'b0;
    latch_cond = 1'b0;
    flag_w     = 2'b00;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    case (state)
      FETCH: begin
        irw       = 1'b1;
        nextpc    = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_nxt = DECODE;
      end
      DECODE: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        latch_cond = 1'b1;
        case (Op)
          OP_MEM:  state_nxt = MEMADR;
          OP_DP:   state_nxt = Funct[5] ? EXECI : EXECR;
          OP_BR:   state_nxt = BRANCH;
          default: state_nxt = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB   = 2'b01;
        state_nxt = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc    = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        regw      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_dec;
        flag_w     = Funct[0] ? flagw_dec : 2'b00;
        state_nxt  = ALUWB;
      end
      ALUWB: begin
        ResultSrc = 2'b00;
        regw      = (cmd != CMD_CMP);
      end
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Write gating: results targeting R15 become PC writes instead of RegWrite
  assign pcs      = branch | (regw & rd_pc);
  assign PCWrite  = reset & (nextpc | (pcs & condex_q));
  assign RegWrite = reset & regw & condex_q & ~rd_pc;
  assign MemWrite = reset & memw & condex_q;
  assign IRWrite  = reset & irw;

  assign ImmSrc = Op;
  assign RegSrc = {Op == OP_MEM, Op == OP_BR};
  assign Flags  = flags_q;
  assign State  = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each instruction's expected per-cycle trace is derived
// from the latency table and condition/flag rules, queued, and compared by an
// independent monitor on the falling edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] Flags;
  logic [3:0] State;

  always #5 clk = ~clk;

  multicycle_controller #(.RESET_FLAGS(4'b0000), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags), .State(State)
  );

  typedef struct {
    int         st;
    bit         pcw, mw, rw, irw, adr, chk_adr;
    logic [3:0] flg;
    int         alu, srcb, rsrc;
    logic [1:0] op;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         passed = 0;
  logic [3:0] mflags;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit cond_holds(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t mk(int st, logic [1:0] op, logic [3:0] f);
    exp_t e;
    e.st = st; e.pcw = 0; e.mw = 0; e.rw = 0; e.irw = 0; e.adr = 0;
    e.chk_adr = 0; e.flg = f; e.alu = -1; e.srcb = -1; e.rsrc = -1; e.op = op;
    return e;
  endfunction

  // Monitor: one expected record per cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("State",    int'(State),    e.st);
      chk("PCWrite",  int'(PCWrite),  int'(e.pcw));
      chk("MemWrite", int'(MemWrite), int'(e.mw));
      chk("RegWrite", int'(RegWrite), int'(e.rw));
      chk("IRWrite",  int'(IRWrite),  int'(e.irw));
      chk("Flags",    int'(Flags),    int'(e.flg));
      chk("ImmSrc",   int'(ImmSrc),   int'(e.op));
      chk("RegSrc",   int'(RegSrc),   int'({e.op == 2'b01, e.op == 2'b10}));
      if (e.chk_adr)   chk("AdrSrc",     int'(AdrSrc),     int'(e.adr));
      if (e.alu >= 0)  chk("ALUControl", int'(ALUControl), e.alu);
      if (e.srcb >= 0) chk("ALUSrcB",    int'(ALUSrcB),    e.srcb);
      if (e.rsrc >= 0) chk("ResultSrc",  int'(ResultSrc),  e.rsrc);
    end
  end

  // Build the expected trace for one instruction, then drive it
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd,
                           input logic [3:0] aluf, input int abort_at);
    exp_t       tr[$];
    exp_t       e;
    bit         ce, nz_only, aborted;
    logic [3:0] f0, f1, cmd;
    int         alu, n;
    f0 = mflags; f1 = mflags; cmd = funct[4:1];
    ce = cond_holds(cond, f0);
    e = mk(0, op, f0); e.pcw = 1; e.irw = 1; e.chk_adr = 1; e.adr = 0;
    e.alu = 0; e.srcb = 2; e.rsrc = 2; tr.push_back(e);
    e = mk(1, op, f0); e.srcb = 2; e.rsrc = 2; tr.push_back(e);
    case (op)
      2'b00: begin
        case (cmd)
          4'b0010, 4'b1010: alu = 1;
          4'b0000:          alu = 2;
          4'b1100:          alu = 3;
          default:          alu = 0;
        endcase
        nz_only = (cmd == 4'b0000) || (cmd == 4'b1100);
        e = mk(funct[5] ? 7 : 6, op, f0); e.alu = alu; e.srcb = funct[5] ? 1 : 0;
        tr.push_back(e);
        if (funct[0] && ce) begin
          f1[3:2] = aluf[3:2];
          if (!nz_only) f1[1:0] = aluf[1:0];
        end
        e = mk(8, op, f1); e.rsrc = 0;
        if (cmd != 4'b1010) begin e.rw = ce && (rd != 4'd15); e.pcw = ce && (rd == 4'd15); end
        tr.push_back(e);
      end
      2'b01: begin
        e = mk(2, op, f0); e.alu = 0; e.srcb = 1; tr.push_back(e);
        if (funct[0]) begin
          e = mk(3, op, f0); e.chk_adr = 1; e.adr = 1; tr.push_back(e);
          e = mk(4, op, f0); e.rsrc = 1;
          e.rw = ce && (rd != 4'd15); e.pcw = ce && (rd == 4'd15); tr.push_back(e);
        end else begin
          e = mk(5, op, f0); e.chk_adr = 1; e.adr = 1; e.mw = ce; tr.push_back(e);
        end
      end
      2'b10: begin
        e = mk(9, op, f0); e.pcw = ce; e.srcb = 1; e.rsrc = 2; tr.push_back(e);
      end
      default: ;
    endcase
    aborted = (abort_at >= 0) && (abort_at < tr.size());
    if (aborted) begin
      while (tr.size() > abort_at + 1) void'(tr.pop_back());
      e = tr.pop_back();
      e.pcw = 0; e.mw = 0; e.rw = 0; e.irw = 0; e.chk_adr = 0;
      e.alu = -1; e.srcb = -1; e.rsrc = -1;
      tr.push_back(e);
      tr.push_back(mk(0, op, 4'b0000));
    end
    n = aborted ? abort_at + 1 : tr.size();
    Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = aluf;
    foreach (tr[i]) q.push_back(tr[i]);
    for (int i = 0; i < n; i++) begin
      if (aborted && i == abort_at) reset = 1'b0;
      @(posedge clk); #1;
    end
    if (aborted) begin
      @(posedge clk); #1;
      reset = 1'b1;
      mflags = 4'b0000;
    end else begin
      mflags = f1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] cmds [5];
    logic [3:0] cmd;
    int         ab;
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
    cmds[3] = 4'b1100; cmds[4] = 4'b1010;
    reset = 1'b0; Cond = 4'd0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    mflags = 4'b0000;
    @(posedge clk); #1;
    q.push_back(mk(0, 2'b00, 4'b0000));
    q.push_back(mk(0, 2'b00, 4'b0000));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed scenarios
    run_instr(4'hE, 2'b00, 6'b101001, 4'd3, 4'b0110, -1); // ADDS imm
    run_instr(4'hE, 2'b00, 6'b101001, 4'd3, 4'b0100, -1); // set Z
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000, -1); // BNE not taken
    run_instr(4'hE, 2'b00, 6'b001001, 4'd2, 4'b0000, -1); // clear flags
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000, -1); // BNE taken
    run_instr(4'hE, 2'b01, 6'b011001, 4'd5, 4'b0000, -1); // LDR
    run_instr(4'hE, 2'b01, 6'b011000, 4'd5, 4'b0000, -1); // STR
    run_instr(4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000, -1); // LDR to PC
    run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b1000, -1); // CMP
    run_instr(4'hE, 2'b00, 6'b011001, 4'd4, 4'b0011, -1); // ORRS
    run_instr(4'hE, 2'b11, 6'b000000, 4'd1, 4'b1111, -1); // undefined
    run_instr(4'hF, 2'b00, 6'b101001, 4'd1, 4'b1111, -1); // Cond=NV
    run_instr(4'hE, 2'b00, 6'b001001, 4'd15, 4'b1011, -1); // ADDS to PC
    run_instr(4'hE, 2'b01, 6'b011001, 4'd6, 4'b0000, 3);  // reset in MEMRD

    // Randomized instruction stream
    for (int k = 0; k < 300; k++) begin
      cmd = cmds[$urandom_range(0, 4)];
      ab  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)),
                {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))},
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ab);
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
